// File: rtl/datapath_multi.sv
// Multi-accumulator datapath: NUM_ACC accumulators, 8-op ALU with Z/N/C/V flags and
// a DATA_WIDTH-cycle shift-add unsigned multiplier behind an exec/busy/done handshake.
module datapath_multi #(
  parameter int DATA_WIDTH    = 16,
  parameter int OPERAND_WIDTH = 11,
  parameter int NUM_ACC       = 4,
  parameter int ACC_SEL_WIDTH = $clog2(NUM_ACC)
) (
  input  logic                     clock_in,
  input  logic                     reset_n_in,
  input  logic                     exec_in,
  input  logic [1:0]               sel_A_in,
  input  logic                     sel_B_in,
  input  logic [2:0]               alu_op_in,
  input  logic [ACC_SEL_WIDTH-1:0] acc_sel_in,
  input  logic                     status_wr_in,
  input  logic                     acc_clear_in,
  input  logic [OPERAND_WIDTH-1:0] operand_in,
  input  logic [DATA_WIDTH-1:0]    data_memory_in,
  output logic [OPERAND_WIDTH-1:0] data_memory_address_out,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic [DATA_WIDTH-1:0]    ext_out,
  output logic                     busy_out,
  output logic                     done_out,
  output logic                     status_Z_out,
  output logic                     status_N_out,
  output logic                     status_C_out,
  output logic                     status_V_out
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MUL  = 1'b1;
  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  logic [DATA_WIDTH-1:0]    acc [NUM_ACC];
  logic [0:0]               state;
  logic [CNT_W-1:0]         cnt;
  logic [2*DATA_WIDTH-1:0]  mcand;
  logic [DATA_WIDTH-1:0]    mplier;
  logic [2*DATA_WIDTH-1:0]  prod;
  logic [2*DATA_WIDTH-1:0]  prod_next;
  logic [ACC_SEL_WIDTH-1:0] mul_sel;
  logic                     mul_swr;

  logic [DATA_WIDTH-1:0] op_a;
  logic [DATA_WIDTH-1:0] op_b;
  logic [DATA_WIDTH:0]   sum_ext;
  logic [DATA_WIDTH:0]   dif_ext;
  logic [DATA_WIDTH-1:0] alu_res;
  logic                  alu_c;
  logic                  alu_v;
  logic                  is_mul;

  assign data_memory_address_out = operand_in;
  assign ext_out  = {{(DATA_WIDTH-OPERAND_WIDTH){operand_in[OPERAND_WIDTH-1]}}, operand_in};
  assign data_out = acc[acc_sel_in];
  assign busy_out = (state == ST_MUL);

  assign op_a    = acc[acc_sel_in];
  assign op_b    = sel_B_in ? ext_out : data_memory_in;
  assign sum_ext = {1'b0, op_a} + {1'b0, op_b};
  // Top bit of the widened difference is the unsigned borrow (A < B).
  assign dif_ext = {1'b0, op_a} - {1'b0, op_b};
  assign is_mul  = (sel_A_in == 2'b10) && (alu_op_in == OP_MUL);

  assign prod_next = prod + (mplier[0] ? mcand : '0);

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (alu_op_in)
      OP_ADD: begin
        alu_res = sum_ext[DATA_WIDTH-1:0];
        alu_c   = sum_ext[DATA_WIDTH];
        alu_v   = (op_a[DATA_WIDTH-1] == op_b[DATA_WIDTH-1]) &&
                  (sum_ext[DATA_WIDTH-1] != op_a[DATA_WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = dif_ext[DATA_WIDTH-1:0];
        alu_c   = dif_ext[DATA_WIDTH];
        alu_v   = (op_a[DATA_WIDTH-1] != op_b[DATA_WIDTH-1]) &&
                  (dif_ext[DATA_WIDTH-1] != op_a[DATA_WIDTH-1]);
      end
      OP_AND: alu_res = op_a & op_b;
      OP_OR:  alu_res = op_a | op_b;
      OP_XOR: alu_res = op_a ^ op_b;
      OP_SHL: begin
        alu_res = {op_a[DATA_WIDTH-2:0], 1'b0};
        alu_c   = op_a[DATA_WIDTH-1];
      end
      OP_SHR: begin
        alu_res = {1'b0, op_a[DATA_WIDTH-1:1]};
        alu_c   = op_a[0];
      end
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clock_in) begin
    if (!reset_n_in || acc_clear_in) begin
      for (int unsigned i = 0; i < NUM_ACC; i++) acc[i] <= '0;
      status_Z_out <= 1'b0;
      status_N_out <= 1'b0;
      status_C_out <= 1'b0;
      status_V_out <= 1'b0;
      state        <= ST_IDLE;
      cnt          <= '0;
      done_out     <= 1'b0;
      mcand        <= '0;
      mplier       <= '0;
      prod         <= '0;
      mul_sel      <= '0;
      mul_swr      <= 1'b0;
    end else begin
      done_out <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (exec_in) begin
            if (is_mul) begin
              mcand   <= (2*DATA_WIDTH)'(op_a);
              mplier  <= op_b;
              prod    <= '0;
              cnt     <= '0;
              mul_sel <= acc_sel_in;
              mul_swr <= status_wr_in;
              state   <= ST_MUL;
            end else begin
              done_out <= 1'b1;
              case (sel_A_in)
                2'b00: acc[acc_sel_in] <= data_memory_in;
                2'b01: acc[acc_sel_in] <= ext_out;
                2'b10: begin
                  acc[acc_sel_in] <= alu_res;
                  if (status_wr_in) begin
                    status_Z_out <= (alu_res == '0);
                    status_N_out <= alu_res[DATA_WIDTH-1];
                    status_C_out <= alu_c;
                    status_V_out <= alu_v;
                  end
                end
                default: ;
              endcase
            end
          end
        end
        default: begin
          prod   <= prod_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          // Final iteration writes prod_next directly so busy spans exactly DATA_WIDTH cycles.
          if (cnt == CNT_W'(DATA_WIDTH - 1)) begin
            acc[mul_sel] <= prod_next[DATA_WIDTH-1:0];
            if (mul_swr) begin
              status_Z_out <= (prod_next[DATA_WIDTH-1:0] == '0);
              status_N_out <= prod_next[DATA_WIDTH-1];
              status_C_out <= |prod_next[2*DATA_WIDTH-1:DATA_WIDTH];
              status_V_out <= 1'b0;
            end
            state    <= ST_IDLE;
            done_out <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_datapath_multi.sv
// Bench for datapath_multi: transaction-level model checked every cycle, directed
// scenarios with literal expectations, then randomized traffic.
module tb_datapath_multi;
  logic        clock_in = 1'b0;
  logic        reset_n_in, exec_in, sel_B_in, status_wr_in, acc_clear_in;
  logic [1:0]  sel_A_in, acc_sel_in;
  logic [2:0]  alu_op_in;
  logic [10:0] operand_in, data_memory_address_out;
  logic [15:0] data_memory_in, data_out, ext_out;
  logic        busy_out, done_out, status_Z_out, status_N_out, status_C_out, status_V_out;

  always #5 clock_in = ~clock_in;

  datapath_multi #(.DATA_WIDTH(16), .OPERAND_WIDTH(11), .NUM_ACC(4)) dut (
    .clock_in(clock_in), .reset_n_in(reset_n_in), .exec_in(exec_in),
    .sel_A_in(sel_A_in), .sel_B_in(sel_B_in), .alu_op_in(alu_op_in),
    .acc_sel_in(acc_sel_in), .status_wr_in(status_wr_in), .acc_clear_in(acc_clear_in),
    .operand_in(operand_in), .data_memory_in(data_memory_in),
    .data_memory_address_out(data_memory_address_out), .data_out(data_out),
    .ext_out(ext_out), .busy_out(busy_out), .done_out(done_out),
    .status_Z_out(status_Z_out), .status_N_out(status_N_out),
    .status_C_out(status_C_out), .status_V_out(status_V_out));

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  logic [15:0] m_acc [4];
  logic [3:0]  m_flags;  // {Z,N,C,V}
  bit          m_busy, m_done, m_swr;
  int          m_rem;
  logic [15:0] m_a, m_b;
  logic [1:0]  m_sel;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] sext(input logic [10:0] x);
    return 16'($signed(x));
  endfunction

  task automatic model_step();
    logic [15:0] a, b, r;
    logic [31:0] p;
    logic        c, v;
    int          s, sa, sb;
    m_done = 0;
    if (!reset_n_in || acc_clear_in) begin
      for (int i = 0; i < 4; i++) m_acc[i] = 16'h0;
      m_flags = 4'b0;
      m_busy  = 0;
    end else if (m_busy) begin
      m_rem--;
      if (m_rem == 0) begin
        p = {16'h0, m_a} * {16'h0, m_b};
        m_acc[m_sel] = p[15:0];
        if (m_swr) m_flags = {p[15:0] == 16'h0, p[15], p[31:16] != 16'h0, 1'b0};
        m_busy = 0;
        m_done = 1;
      end
    end else if (exec_in) begin
      a  = m_acc[acc_sel_in];
      b  = sel_B_in ? sext(operand_in) : data_memory_in;
      sa = $signed(a);
      sb = $signed(b);
      m_done = 1;
      case (sel_A_in)
        2'd0: m_acc[acc_sel_in] = data_memory_in;
        2'd1: m_acc[acc_sel_in] = sext(operand_in);
        2'd2: begin
          if (alu_op_in == 3'd7) begin
            m_a = a; m_b = b; m_sel = acc_sel_in; m_swr = status_wr_in;
            m_busy = 1; m_rem = 16; m_done = 0;
          end else begin
            c = 0; v = 0; r = 16'h0;
            case (alu_op_in)
              3'd0: begin s = int'(a) + int'(b); r = s[15:0]; c = s > 65535;
                          v = (sa + sb > 32767) || (sa + sb < -32768); end
              3'd1: begin r = a - b; c = a < b;
                          v = (sa - sb > 32767) || (sa - sb < -32768); end
              3'd2: r = a & b;
              3'd3: r = a | b;
              3'd4: r = a ^ b;
              3'd5: begin r = a << 1; c = a[15]; end
              default: begin r = a >> 1; c = a[0]; end
            endcase
            m_acc[acc_sel_in] = r;
            if (status_wr_in) m_flags = {r == 16'h0, r[15], c, v};
          end
        end
        default: ;
      endcase
    end
  endtask

  initial forever begin
    @(posedge clock_in);
    model_step();
  end

  initial forever begin
    @(negedge clock_in);
    if (chk_en) begin
      chk("data_out", data_out, m_acc[acc_sel_in]);
      chk("busy", busy_out, m_busy);
      chk("done", done_out, m_done);
      chk("flags", {status_Z_out, status_N_out, status_C_out, status_V_out}, m_flags);
      chk("ext", ext_out, sext(operand_in));
      chk("addr", data_memory_address_out, operand_in);
    end
  end

  task automatic step();
    @(posedge clock_in);
    #1;
  endtask

  task automatic cmd(input logic [1:0] sa, input logic sb, input logic [2:0] op,
                     input logic [1:0] sel, input logic swr, input logic [10:0] opnd,
                     input logic [15:0] dm);
    sel_A_in = sa; sel_B_in = sb; alu_op_in = op; acc_sel_in = sel;
    status_wr_in = swr; operand_in = opnd; data_memory_in = dm; exec_in = 1;
    step();
    exec_in = 0;
  endtask

  task automatic lit(input string name, input logic [1:0] sel, input logic [15:0] exp);
    exec_in = 0;
    acc_sel_in = sel;
    @(negedge clock_in);
    chk(name, data_out, exp);
    step();
  endtask

  task automatic lit_flags(input string name, input logic [3:0] exp);
    chk(name, {status_Z_out, status_N_out, status_C_out, status_V_out}, exp);
  endtask

  // Counts busy cycles; optionally injects a load command at busy cycle 5.
  task automatic wait_busy(input bit inject, output int n);
    n = 0;
    while (busy_out && n < 40) begin
      if (inject && n == 5) begin
        exec_in = 1; sel_A_in = 2'b01; acc_sel_in = 2'd3; operand_in = 11'h555;
      end else exec_in = 0;
      n++;
      step();
    end
    exec_in = 0;
    chk("mul_finished", busy_out, 0);
  endtask

  initial begin
    int n;
    reset_n_in = 0; acc_clear_in = 0; exec_in = 0; sel_A_in = 2'b11; sel_B_in = 0;
    alu_op_in = 0; acc_sel_in = 0; status_wr_in = 0; operand_in = 0; data_memory_in = 0;
    step();
    chk_en = 1;
    step();
    reset_n_in = 1;

    // 1: reset state and loads
    for (int i = 0; i < 4; i++) lit("reset_acc", 2'(i), 16'h0000);
    lit_flags("reset_flags", 4'b0000);
    chk("reset_busy", busy_out, 0);
    chk("reset_done", done_out, 0);
    cmd(2'b01, 0, 3'd0, 2'd0, 1, 11'h7FF, 16'h0);
    chk("load_done", done_out, 1);
    lit("load_acc0", 2'd0, 16'hFFFF);
    lit_flags("load_flags", 4'b0000);
    cmd(2'b01, 0, 3'd0, 2'd1, 1, 11'h3FF, 16'h0);
    lit("load_acc1", 2'd1, 16'h03FF);
    lit("acc0_hold", 2'd0, 16'hFFFF);

    // 2: flags
    cmd(2'b10, 0, 3'd0, 2'd0, 1, 11'h0, 16'h0001);
    lit("add_res", 2'd0, 16'h0000);
    lit_flags("add_flags", 4'b1010);
    cmd(2'b10, 0, 3'd1, 2'd0, 0, 11'h0, 16'h0001);
    lit("sub_nowr_res", 2'd0, 16'hFFFF);
    lit_flags("sub_nowr_flags", 4'b1010);

    // 3: signed overflow
    cmd(2'b00, 0, 3'd0, 2'd2, 1, 11'h0, 16'h7FFF);
    cmd(2'b10, 0, 3'd1, 2'd2, 1, 11'h0, 16'hFFFF);
    lit("ovf_res", 2'd2, 16'h8000);
    lit_flags("ovf_flags", 4'b0111);

    // 4: multiply with ignored exec mid-flight
    cmd(2'b01, 0, 3'd0, 2'd3, 1, 11'h012, 16'h0);
    cmd(2'b10, 0, 3'd7, 2'd3, 1, 11'h0, 16'h0034);
    chk("mul_no_early_done", done_out, 0);
    wait_busy(1, n);
    chk("mul_cycles", n, 16);
    chk("mul_done", done_out, 1);
    lit("mul_res", 2'd3, 16'h03A8);
    lit_flags("mul_flags", 4'b0000);

    // 5: multiply overflow and SHL1
    cmd(2'b01, 0, 3'd0, 2'd0, 1, 11'h100, 16'h0);
    cmd(2'b10, 1, 3'd7, 2'd0, 1, 11'h100, 16'h0);
    wait_busy(0, n);
    lit("mulovf_res", 2'd0, 16'h0000);
    lit_flags("mulovf_flags", 4'b1010);
    cmd(2'b00, 0, 3'd0, 2'd1, 1, 11'h0, 16'h8001);
    cmd(2'b10, 0, 3'd5, 2'd1, 1, 11'h0, 16'h0);
    lit("shl_res", 2'd1, 16'h0002);
    lit_flags("shl_flags", 4'b0010);

    // 6: abort by reset, then clear concurrent with exec
    cmd(2'b10, 0, 3'd7, 2'd3, 1, 11'h0, 16'h0003);
    repeat (4) step();
    reset_n_in = 0;
    step();
    reset_n_in = 1;
    chk("abort_busy", busy_out, 0);
    chk("abort_done", done_out, 0);
    for (int i = 0; i < 4; i++) lit("abort_acc", 2'(i), 16'h0000);
    lit_flags("abort_flags", 4'b0000);
    cmd(2'b01, 0, 3'd0, 2'd2, 1, 11'h055, 16'h0);
    lit("pre_clear", 2'd2, 16'h0055);
    acc_clear_in = 1;
    cmd(2'b01, 0, 3'd0, 2'd2, 1, 11'h123, 16'h0);
    acc_clear_in = 0;
    chk("clear_done", done_out, 0);
    lit("clear_acc", 2'd2, 16'h0000);

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      reset_n_in     = ($urandom_range(0, 199) != 0);
      acc_clear_in   = ($urandom_range(0, 79) == 0);
      exec_in        = ($urandom_range(0, 2) != 0);
      sel_A_in       = 2'($urandom);
      sel_B_in       = 1'($urandom);
      alu_op_in      = ($urandom_range(0, 3) == 0) ? 3'd7 : 3'($urandom);
      acc_sel_in     = 2'($urandom);
      status_wr_in   = 1'($urandom);
      operand_in     = 11'($urandom);
      data_memory_in = ($urandom_range(0, 5) == 0) ? 16'hFFFF : 16'($urandom);
      step();
    end
    reset_n_in = 1; acc_clear_in = 0; exec_in = 0;
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/datapath_multi.md
Name: datapath_multi

Overview:
- Parametrised successor to the single-accumulator datapath.
- Contains NUM_ACC accumulators, an 8-operation ALU with Z/N/C/V status, and a multi-cycle unsigned multiplier.
- Uses an exec/busy/done handshake toward the control unit.
- Sits between the control FSM and data memory; operand and address come from the instruction operand field.

Parameters:
- DATA_WIDTH, 16, width of accumulators, ALU, memory data.
- OPERAND_WIDTH, 11, width of instruction operand and data memory address.
- NUM_ACC, 4, number of accumulators (power of 2, >=2).
- ACC_SEL_WIDTH, $clog2(NUM_ACC), accumulator select width (derived; not overridden).

Ports:
- clock_in  input  1  single clock, rising edge
- reset_n_in  input  1  synchronous, active-low reset
- exec_in  input  1  command strobe; accepted only when busy_out=0
- sel_A_in  input  2  accumulator write source: 00 data_memory_in, 01 ext, 10 ALU, 11 no write
- sel_B_in  input  1  ALU B operand: 1 ext, 0 data_memory_in
- alu_op_in  input  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL1, 110 SHR1, 111 MUL
- acc_sel_in  input  ACC_SEL_WIDTH  target accumulator; also the read-port select
- status_wr_in  input  1  update flags on an ALU command
- acc_clear_in  input  1  clear all accumulators and status
- operand_in  input  OPERAND_WIDTH  instruction operand
- data_memory_in  input  DATA_WIDTH  memory read data
- data_memory_address_out  output  OPERAND_WIDTH  equals operand_in (combinational)
- data_out  output  DATA_WIDTH  acc[acc_sel_in] (combinational)
- ext_out  output  DATA_WIDTH  sign-extended operand_in
- busy_out  output  1  multiply in progress
- done_out  output  1  one-cycle pulse: command completed
- status_Z_out, status_N_out, status_C_out, status_V_out  output  1 each  registered flags

Behaviour:
- Reset (reset_n_in=0 at an edge):
  - Clears all accumulators, flags, busy_out, done_out, the iteration counter; state returns to IDLE.
  - Applies in any state, including mid-MUL: the multiply is aborted and no done_out is produced.
- acc_clear_in=1 (reset inactive): same clearing as reset. Any exec_in in that cycle is dropped; no done_out is produced.
- ext: operand_in sign-extended to DATA_WIDTH.
- States: IDLE, MUL. busy_out = (state==MUL).
- Accept: exec_in=1 && state==IDLE at edge T0.
  - Non-MUL command, or sel_A_in!=10: result written at T0; done_out=1 for the cycle after T0.
  - sel_A_in=11: no write and no flag change, but done_out still pulses.
- Single-cycle ALU results, A = acc[acc_sel_in], B = sel_B mux, all mod 2^DATA_WIDTH:
  - ADD: C = carry out; V = signed overflow.
  - SUB: A-B; C = borrow (A<B unsigned); V = signed overflow.
  - AND/OR/XOR: C=0, V=0.
  - SHL1: A<<1; C = A[MSB]; V=0.
  - SHR1: logical A>>1; C = A[0]; V=0.
  - Z = (result==0); N = result[MSB].
- Flags update only when sel_A_in=10 && status_wr_in=1 at acceptance. Loads (sel_A 00/01) never change flags.
- MUL (alu_op=111 with sel_A=10):
  - At T0: latch A, B, acc_sel, status_wr; enter MUL; counter=0.
  - One shift-add iteration per edge, T1..T(DATA_WIDTH).
  - At edge T(DATA_WIDTH): write the low DATA_WIDTH bits of the unsigned product to the latched accumulator; return to IDLE.
  - done_out=1 during the following cycle.
  - busy_out is high for exactly DATA_WIDTH cycles.
  - Flags (if latched status_wr): Z, N from the low half; C = (high half != 0); V=0.
- MUL with sel_A!=10: ALU op ignored; normal single-cycle path.
- exec_in while busy_out=1: ignored entirely. It is not queued.
- Input changes during MUL do not affect the result, since operands are latched.
- Only acc[acc_sel] is ever written; the other accumulators hold.
- done_out never overlaps busy_out.

Test Plan:
All cases use defaults (DATA_WIDTH=16, OPERAND_WIDTH=11, NUM_ACC=4).
1. Reset: hold reset_n_in=0 2 cycles -> all acc 0, flags 0, busy_out=0, done_out=0. Then exec sel_A=01 operand 0x7FF into acc0 -> acc0=0xFFFF, done_out 1 cycle, flags unchanged. Exec sel_A=01 operand 0x3FF into acc1 -> acc1=0x03FF, acc0 unchanged.
2. Flags: acc0=0xFFFF; ADD with data_memory_in=0x0001, status_wr=1 -> acc0=0x0000, Z=1, N=0, C=1, V=0. Then same with status_wr=0 on SUB -> flags hold.
3. Signed overflow: acc2=0x7FFF; SUB B=0xFFFF from memory -> acc2=0x8000, N=1, C=1, V=1, Z=0.
4. Multiply: acc3=0x0012; MUL B=0x0034 -> busy_out high 16 cycles, then acc3=0x03A8, C=0, done_out pulse. An exec_in at busy cycle 5 has no effect.
5. MUL overflow: acc0=0x0100 * 0x0100 -> acc0=0x0000, Z=1, C=1. Also cover SHL1 of 0x8001 -> 0x0002, C=1.
6. Abort: reset_n_in=0 at MUL iteration 5 -> next cycle busy_out=0, all acc 0, no done_out. acc_clear_in concurrent with exec_in -> everything cleared, no write, no done_out.
